sprite_anim_addr: RTL and testbench

- Upstream address generator for a palette-indexed sprite renderer. It drives the 14-bit sprite ROM address the renderer consumes.
- Maps the current VGA pixel (drawX, drawY) onto a sprite placed at a latched screen position. Supports optional horizontal mirroring.
- Sequences a multi-frame animation (e.g. a character's lose/KO pose) advanced by per-frame vblank ticks.

---
 rtl/sprite_anim_addr.sv | 163 ++++++++++++++++
 tb/tb_sprite_anim_addr.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_addr.sv
// Sprite ROM address generator: maps the VGA pixel onto a latched sprite box
// and sequences a tick-driven multi-frame animation.
module sprite_anim_addr #(
    parameter int SPR_W      = 64,
    parameter int SPR_H      = 64,
    parameter int NUM_FRAMES = 4,
    parameter int HOLD_TICKS = 6,
    parameter int ADDR_W     = 14
) (
    input  logic                          vga_clk,
    input  logic                          reset,
    input  logic [9:0]                    drawX,
    input  logic [9:0]                    drawY,
    input  logic                          frame_tick,
    input  logic [9:0]                    sprite_x,
    input  logic [9:0]                    sprite_y,
    input  logic                          flip_h,
    input  logic                          play,
    input  logic                          loop_en,
    output logic [ADDR_W-1:0]             rom_address,
    output logic                          in_sprite,
    output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
    output logic                          anim_done
);

    localparam int WB = $clog2(SPR_W);
    localparam int HB = $clog2(SPR_H);
    localparam int FW = $clog2(NUM_FRAMES);
    localparam int CW = $clog2(HOLD_TICKS);
    localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPR_W * SPR_H);
    localparam logic [FW-1:0]     LAST_FR  = FW'(NUM_FRAMES - 1);
    localparam logic [CW-1:0]     LAST_CNT = CW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_n;
    logic [9:0]          r_pos_x;
    logic [9:0]          r_pos_y;
    logic                r_flip;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_n;
    logic [FW-1:0]       r_frame;
    logic [FW-1:0]       w_frame_n;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   w_base_n;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_in;
    logic                r_done;

    logic [10:0]         w_x;
    logic [10:0]         w_y;
    logic [10:0]         w_px;
    logic [10:0]         w_py;
    logic                w_in;
    logic [WB-1:0]       w_dx;
    logic [HB-1:0]       w_dy;
    logic [WB-1:0]       w_col;
    logic [ADDR_W-1:0]   w_off;
    logic [ADDR_W-1:0]   w_addr;

    // 11-bit compare so pos + SPR_W cannot wrap at the right/bottom edge
    assign w_x  = {1'b0, drawX};
    assign w_y  = {1'b0, drawY};
    assign w_px = {1'b0, r_pos_x};
    assign w_py = {1'b0, r_pos_y};

    assign w_in = (w_x >= w_px) && (w_x < w_px + 11'(SPR_W)) &&
                  (w_y >= w_py) && (w_y < w_py + 11'(SPR_H));

    assign w_dx   = WB'(drawX - r_pos_x);
    assign w_dy   = HB'(drawY - r_pos_y);
    // SPR_W-1-dx is a bitwise invert because SPR_W is a power of two
    assign w_col  = r_flip ? ~w_dx : w_dx;
    assign w_off  = ADDR_W'({w_dy, w_col});
    assign w_addr = w_in ? (r_base + w_off) : '0;

    // r_base tracks frame*SPR_W*SPR_H incrementally, avoiding a multiplier
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_frame_n = r_frame;
        w_base_n  = r_base;
        if (play) begin
            w_state_n = S_PLAY;
            w_cnt_n   = '0;
            w_frame_n = '0;
            w_base_n  = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_cnt_n   = '0;
                    w_frame_n = '0;
                    w_base_n  = '0;
                end
                S_PLAY: begin
                    if (frame_tick) begin
                        if (r_cnt == LAST_CNT) begin
                            w_cnt_n = '0;
                            if (r_frame == LAST_FR) begin
                                if (loop_en) begin
                                    w_frame_n = '0;
                                    w_base_n  = '0;
                                end else begin
                                    w_state_n = S_DONE;
                                end
                            end else begin
                                w_frame_n = r_frame + FW'(1);
                                w_base_n  = r_base + FRAME_SZ;
                            end
                        end else begin
                            w_cnt_n = r_cnt + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    w_cnt_n = '0;
                end
                default: begin
                    w_state_n = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pos_x <= '0;
            r_pos_y <= '0;
            r_flip  <= 1'b0;
            r_cnt   <= '0;
            r_frame <= '0;
            r_base  <= '0;
            r_addr  <= '0;
            r_in    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_frame <= w_frame_n;
            r_base  <= w_base_n;
            r_addr  <= w_addr;
            r_in    <= w_in;
            r_done  <= (w_state_n == S_DONE);
            if (frame_tick) begin
                r_pos_x <= sprite_x;
                r_pos_y <= sprite_y;
                r_flip  <= flip_h;
            end
        end
    end

    assign rom_address = r_addr;
    assign in_sprite   = r_in;
    assign frame_idx   = r_frame;
    assign anim_done   = r_done;

endmodule

// File: tb/tb_sprite_anim_addr.sv
// Bench for sprite_anim_addr: directed literal checks plus randomized traffic
// compared every cycle against an elapsed-tick behavioural model.
module tb_sprite_anim_addr;

    localparam int SPR_W      = 64;
    localparam int SPR_H      = 64;
    localparam int NUM_FRAMES = 4;
    localparam int HOLD_TICKS = 6;
    localparam int ADDR_W     = 14;

    logic              vga_clk = 1'b0;
    logic              reset;
    logic [9:0]        drawX;
    logic [9:0]        drawY;
    logic              frame_tick;
    logic [9:0]        sprite_x;
    logic [9:0]        sprite_y;
    logic              flip_h;
    logic              play;
    logic              loop_en;
    logic [ADDR_W-1:0] rom_address;
    logic              in_sprite;
    logic [1:0]        frame_idx;
    logic              anim_done;

    int n_chk  = 0;
    int n_fail = 0;

    sprite_anim_addr #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NUM_FRAMES),
        .HOLD_TICKS(HOLD_TICKS), .ADDR_W(ADDR_W)
    ) dut (
        .vga_clk(vga_clk), .reset(reset),
        .drawX(drawX), .drawY(drawY),
        .frame_tick(frame_tick),
        .sprite_x(sprite_x), .sprite_y(sprite_y),
        .flip_h(flip_h), .play(play), .loop_en(loop_en),
        .rom_address(rom_address), .in_sprite(in_sprite),
        .frame_idx(frame_idx), .anim_done(anim_done)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: shadow position, plus animation as "ticks elapsed since play"
    int m_px = 0, m_py = 0;
    bit m_flip = 0;
    bit m_active = 0, m_done = 0;
    int m_elapsed = 0;
    int e_addr, e_frame, x, y, dx, dy;
    bit e_in, e_done;
    bit chk_en = 0;

    function automatic int mframe();
        if (m_done) return NUM_FRAMES - 1;
        if (!m_active) return 0;
        return m_elapsed / HOLD_TICKS;
    endfunction

    always @(posedge vga_clk) begin
        if (reset) begin
            e_addr = 0; e_in = 0;
            m_px = 0; m_py = 0; m_flip = 0;
            m_active = 0; m_done = 0; m_elapsed = 0;
        end else begin
            x = int'(drawX);
            y = int'(drawY);
            e_in = (x >= m_px) && (x < m_px + SPR_W) &&
                   (y >= m_py) && (y < m_py + SPR_H);
            dx = x - m_px;
            dy = y - m_py;
            e_addr = e_in ? mframe() * SPR_W * SPR_H + dy * SPR_W +
                            (m_flip ? SPR_W - 1 - dx : dx) : 0;
            if (play) begin
                m_active = 1; m_done = 0; m_elapsed = 0;
            end else if (frame_tick && m_active && !m_done) begin
                m_elapsed++;
                if (m_elapsed == HOLD_TICKS * NUM_FRAMES) begin
                    if (loop_en) m_elapsed = 0;
                    else m_done = 1;
                end
            end
            if (frame_tick) begin
                m_px = int'(sprite_x);
                m_py = int'(sprite_y);
                m_flip = flip_h;
            end
        end
        e_frame = mframe();
        e_done = m_done;
        #1;
        if (chk_en) begin
            chk("mdl_addr", int'(rom_address), e_addr);
            chk("mdl_in", int'(in_sprite), int'(e_in));
            chk("mdl_frame", int'(frame_idx), e_frame);
            chk("mdl_done", int'(anim_done), int'(e_done));
        end
        if (reset) chk_en = 1;
    end

    task automatic pix(input int px, input int py, input int ea, input int ei,
                       input string nm);
        drawX = 10'(px);
        drawY = 10'(py);
        @(negedge vga_clk);
        chk({nm, "_addr"}, int'(rom_address), ea);
        chk({nm, "_in"}, int'(in_sprite), ei);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge vga_clk);
        frame_tick = 1'b0;
        @(negedge vga_clk);
    endtask

    task automatic do_play();
        play = 1'b1;
        @(negedge vga_clk);
        play = 1'b0;
    endtask

    initial begin
        reset = 1'b1; drawX = '0; drawY = '0; frame_tick = 1'b0;
        sprite_x = '0; sprite_y = '0; flip_h = 1'b0;
        play = 1'b0; loop_en = 1'b0;
        repeat (3) @(negedge vga_clk);
        chk("rst_addr", int'(rom_address), 0);
        chk("rst_in", int'(in_sprite), 0);
        chk("rst_frame", int'(frame_idx), 0);
        chk("rst_done", int'(anim_done), 0);
        reset = 1'b0;

        sprite_x = 10'd100; sprite_y = 10'd50; flip_h = 1'b0;
        tick();
        pix(100, 50, 0, 1, "origin");
        pix(163, 50, 63, 1, "right_col");
        pix(164, 50, 0, 0, "past_right");

        flip_h = 1'b1;
        tick();
        pix(100, 51, 127, 1, "flip_left");
        pix(163, 51, 64, 1, "flip_right");

        sprite_x = 10'd300;
        pix(100, 51, 127, 1, "shadow_hold");
        tick();
        pix(300, 51, 127, 1, "shadow_new");
        pix(100, 51, 0, 0, "shadow_old");

        sprite_x = 10'd600; sprite_y = 10'd440; flip_h = 1'b0;
        tick();
        pix(639, 479, 2535, 1, "edge");

        sprite_x = 10'd100; sprite_y = 10'd50;
        tick();
        loop_en = 1'b0;
        do_play();
        for (int k = 1; k <= 24; k++) begin
            tick();
            chk("seq_frame", int'(frame_idx), (k / 6 > 3) ? 3 : k / 6);
            if (k == 12) pix(101, 52, 8321, 1, "frame2");
        end
        chk("seq_done", int'(anim_done), 1);

        loop_en = 1'b1;
        do_play();
        chk("replay_done", int'(anim_done), 0);
        repeat (24) tick();
        chk("loop_frame", int'(frame_idx), 0);
        chk("loop_done", int'(anim_done), 0);
        repeat (12) tick();
        chk("loop_f2", int'(frame_idx), 2);
        play = 1'b1; frame_tick = 1'b1;
        @(negedge vga_clk);
        play = 1'b0; frame_tick = 1'b0;
        @(negedge vga_clk);
        chk("play_tick", int'(frame_idx), 0);
        repeat (5) tick();
        chk("cnt_clear5", int'(frame_idx), 0);
        tick();
        chk("cnt_clear6", int'(frame_idx), 1);

        repeat (6) tick();
        chk("pre_rst_f2", int'(frame_idx), 2);
        pix(110, 60, 2 * 4096 + 10 * 64 + 10, 1, "pre_rst");
        reset = 1'b1;
        @(negedge vga_clk);
        chk("mid_rst_addr", int'(rom_address), 0);
        chk("mid_rst_in", int'(in_sprite), 0);
        chk("mid_rst_frame", int'(frame_idx), 0);
        chk("mid_rst_done", int'(anim_done), 0);
        reset = 1'b0;
        repeat (6) tick();
        chk("idle_frame", int'(frame_idx), 0);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 999) == 0);
            play = ($urandom_range(0, 149) == 0);
            frame_tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
            sprite_x = 10'($urandom_range(0, 1023));
            sprite_y = 10'($urandom_range(0, 1023));
            flip_h = 1'($urandom_range(0, 1));
            drawX = 10'((m_px + int'($urandom_range(0, 80)) + 1016) % 1024);
            drawY = 10'((m_py + int'($urandom_range(0, 80)) + 1016) % 1024);
            @(negedge vga_clk);
        end
        reset = 1'b0; play = 1'b0; frame_tick = 1'b0;
        repeat (2) @(negedge vga_clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
